// File: rtl/hpdcache_mem_read_bridge.sv
// hpdcache_mem_read_bridge
//
// Credit-based bridge on the HPDcache read channel. Read requests pass
// straight through to the memory interconnect, but only while a response
// slot can be guaranteed for them: the number of in-flight requests plus
// the number of buffered responses never exceeds the response buffer depth.
// Because of that, memory responses are always accepted (no backpressure
// toward the interconnect) and are replayed to the cache in arrival order.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cache_req_*                   read request from the cache (valid/ready, addr, id)
//   mem_req_*                     read request toward memory (valid/ready, addr, id)
//   mem_rsp_*                     response from memory (valid/ready, data, id, error)
//   cache_rsp_*                   buffered response toward the cache
//   inflight_o                    number of issued requests still awaiting a response
//   err_unexpected_o              sticky: a response arrived with nothing in flight

module hpdcache_mem_read_bridge #(
    parameter int MaxOutstanding = 4,
    parameter int RspFifoDepth   = 4,
    parameter int AddrWidth      = 56,
    parameter int IdWidth        = 7,
    parameter int DataWidth      = 512
) (
    input  logic                                clk_i,
    input  logic                                rst_i,

    input  logic                                cache_req_valid_i,
    output logic                                cache_req_ready_o,
    input  logic [AddrWidth-1:0]                cache_req_addr_i,
    input  logic [IdWidth-1:0]                  cache_req_id_i,

    output logic                                mem_req_valid_o,
    input  logic                                mem_req_ready_i,
    output logic [AddrWidth-1:0]                mem_req_addr_o,
    output logic [IdWidth-1:0]                  mem_req_id_o,

    input  logic                                mem_rsp_valid_i,
    output logic                                mem_rsp_ready_o,
    input  logic [DataWidth-1:0]                mem_rsp_data_i,
    input  logic [IdWidth-1:0]                  mem_rsp_id_i,
    input  logic                                mem_rsp_error_i,

    output logic                                cache_rsp_valid_o,
    input  logic                                cache_rsp_ready_i,
    output logic [DataWidth-1:0]                cache_rsp_data_o,
    output logic [IdWidth-1:0]                  cache_rsp_id_o,
    output logic                                cache_rsp_error_o,

    output logic [$clog2(MaxOutstanding+1)-1:0] inflight_o,
    output logic                                err_unexpected_o
);

    localparam int IW = $clog2(MaxOutstanding + 1);
    localparam int CW = $clog2(RspFifoDepth + 1);
    localparam int PW = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
    // One extra bit so inflight + count cannot wrap.
    localparam int SW = ((IW > CW) ? IW : CW) + 1;
    localparam int EW = DataWidth + IdWidth + 1;

    logic [IW-1:0] inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          err_unexpected;
    logic [EW-1:0] storage [RspFifoDepth];

    logic [SW-1:0] credit_used;
    logic          can_issue;
    logic          issue;
    logic          rsp_fire;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(RspFifoDepth - 1)) ? '0 : p + PW'(1);
    endfunction

    assign credit_used = SW'(inflight) + SW'(count);
    assign can_issue   = (inflight < IW'(MaxOutstanding)) &&
                         (credit_used < SW'(RspFifoDepth));

    // Request path is a pure pass-through gated by credit; reset gating keeps
    // the handshakes quiet while rst_i is held.
    assign mem_req_valid_o   = cache_req_valid_i & can_issue & ~rst_i;
    assign cache_req_ready_o = mem_req_ready_i & can_issue & ~rst_i;
    assign mem_req_addr_o    = cache_req_addr_i;
    assign mem_req_id_o      = cache_req_id_i;
    assign issue             = mem_req_valid_o & mem_req_ready_i;

    // Buffer space is reserved at issue time, so responses are never stalled.
    assign mem_rsp_ready_o = ~rst_i;
    assign rsp_fire        = mem_rsp_valid_i & mem_rsp_ready_o;
    assign push            = rsp_fire & (inflight != '0);

    assign cache_rsp_valid_o = (count != '0);
    assign pop               = cache_rsp_valid_o & cache_rsp_ready_i;

    // Storage is not reset; an empty buffer presents zeros instead of stale/X data.
    assign head              = cache_rsp_valid_o ? storage[rptr] : '0;
    assign cache_rsp_error_o = head[EW-1];
    assign cache_rsp_id_o    = head[DataWidth +: IdWidth];
    assign cache_rsp_data_o  = head[DataWidth-1:0];

    assign inflight_o       = inflight;
    assign err_unexpected_o = err_unexpected;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight       <= '0;
            count          <= '0;
            wptr           <= '0;
            rptr           <= '0;
            err_unexpected <= 1'b0;
        end else begin
            case ({issue, push})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (push) begin
                wptr <= ptr_next(wptr);
            end
            if (pop) begin
                rptr <= ptr_next(rptr);
            end

            // A response with nothing outstanding is dropped and flagged.
            if (rsp_fire && (inflight == '0)) begin
                err_unexpected <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            storage[wptr] <= {mem_rsp_error_i, mem_rsp_id_i, mem_rsp_data_i};
        end
    end

endmodule

// File: tb/tb_hpdcache_mem_read_bridge.sv
// Directed testbench for hpdcache_mem_read_bridge.
// Two instances share all inputs: dut (MaxOutstanding=4, RspFifoDepth=4) and
// d8 (MaxOutstanding=4, RspFifoDepth=8), the latter used where the outstanding
// cap must be distinguished from the buffer-credit limit.

module tb_hpdcache_mem_read_bridge;

    localparam int AW = 56;
    localparam int IDW = 7;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic [IDW-1:0] req_id;
    logic          mreq_ready;
    logic          mrsp_valid;
    logic [DW-1:0] mrsp_data;
    logic [IDW-1:0] mrsp_id;
    logic          mrsp_error;
    logic          crsp_ready;

    // dut outputs
    logic          a_req_ready, a_mreq_valid, a_mrsp_ready, a_crsp_valid, a_crsp_error, a_err;
    logic [AW-1:0] a_mreq_addr;
    logic [IDW-1:0] a_mreq_id, a_crsp_id;
    logic [DW-1:0] a_crsp_data;
    logic [2:0]    a_inflight;

    // d8 outputs
    logic          b_req_ready, b_mreq_valid, b_mrsp_ready, b_crsp_valid, b_crsp_error, b_err;
    logic [AW-1:0] b_mreq_addr;
    logic [IDW-1:0] b_mreq_id, b_crsp_id;
    logic [DW-1:0] b_crsp_data;
    logic [2:0]    b_inflight;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hpdcache_mem_read_bridge #(.MaxOutstanding(4), .RspFifoDepth(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .cache_req_valid_i(req_valid), .cache_req_ready_o(a_req_ready),
        .cache_req_addr_i(req_addr), .cache_req_id_i(req_id),
        .mem_req_valid_o(a_mreq_valid), .mem_req_ready_i(mreq_ready),
        .mem_req_addr_o(a_mreq_addr), .mem_req_id_o(a_mreq_id),
        .mem_rsp_valid_i(mrsp_valid), .mem_rsp_ready_o(a_mrsp_ready),
        .mem_rsp_data_i(mrsp_data), .mem_rsp_id_i(mrsp_id), .mem_rsp_error_i(mrsp_error),
        .cache_rsp_valid_o(a_crsp_valid), .cache_rsp_ready_i(crsp_ready),
        .cache_rsp_data_o(a_crsp_data), .cache_rsp_id_o(a_crsp_id),
        .cache_rsp_error_o(a_crsp_error),
        .inflight_o(a_inflight), .err_unexpected_o(a_err)
    );

    hpdcache_mem_read_bridge #(.MaxOutstanding(4), .RspFifoDepth(8)) d8 (
        .clk_i(clk), .rst_i(rst),
        .cache_req_valid_i(req_valid), .cache_req_ready_o(b_req_ready),
        .cache_req_addr_i(req_addr), .cache_req_id_i(req_id),
        .mem_req_valid_o(b_mreq_valid), .mem_req_ready_i(mreq_ready),
        .mem_req_addr_o(b_mreq_addr), .mem_req_id_o(b_mreq_id),
        .mem_rsp_valid_i(mrsp_valid), .mem_rsp_ready_o(b_mrsp_ready),
        .mem_rsp_data_i(mrsp_data), .mem_rsp_id_i(mrsp_id), .mem_rsp_error_i(mrsp_error),
        .cache_rsp_valid_o(b_crsp_valid), .cache_rsp_ready_i(crsp_ready),
        .cache_rsp_data_o(b_crsp_data), .cache_rsp_id_o(b_crsp_id),
        .cache_rsp_error_o(b_crsp_error),
        .inflight_o(b_inflight), .err_unexpected_o(b_err)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        req_addr   = '0;
        req_id     = '0;
        mreq_ready = 1'b1;
        mrsp_valid = 1'b0;
        mrsp_data  = '0;
        mrsp_id    = '0;
        mrsp_error = 1'b0;
        crsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        req_valid = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        #1;
        total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", a_req_ready); end
        total++; if (a_mreq_valid !== 1'b0) begin bad++; $display("FAIL rst_mreq_valid got=%b exp=0", a_mreq_valid); end
        total++; if (a_mrsp_ready !== 1'b0) begin bad++; $display("FAIL rst_mrsp_ready got=%b exp=0", a_mrsp_ready); end
        total++; if (a_crsp_valid !== 1'b0) begin bad++; $display("FAIL rst_crsp_valid got=%b exp=0", a_crsp_valid); end
        total++; if (a_inflight !== 3'd0) begin bad++; $display("FAIL rst_inflight got=%0d exp=0", a_inflight); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", a_err); end
        total++; if (a_crsp_data !== '0) begin bad++; $display("FAIL rst_crsp_data got=%h exp=0", a_crsp_data[31:0]); end
        rst = 1'b0;
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] pat;
        pat = {16{32'hA5A5_A5A5}};
        do_reset();
        req_valid = 1'b1;
        req_addr  = 56'h1000;
        req_id    = 7'd5;
        #1;
        total++; if (a_mreq_valid !== 1'b1) begin bad++; $display("FAIL basic_mreq_valid got=%b exp=1", a_mreq_valid); end
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL basic_req_ready got=%b exp=1", a_req_ready); end
        total++; if (a_mreq_addr !== 56'h1000) begin bad++; $display("FAIL basic_addr got=%h exp=1000", a_mreq_addr); end
        total++; if (a_mreq_id !== 7'd5) begin bad++; $display("FAIL basic_id got=%0d exp=5", a_mreq_id); end
        tick();
        req_valid  = 1'b0;
        mrsp_valid = 1'b1;
        mrsp_data  = pat;
        mrsp_id    = 7'd5;
        #1;
        total++; if (a_inflight !== 3'd1) begin bad++; $display("FAIL basic_inflight1 got=%0d exp=1", a_inflight); end
        total++; if (a_mrsp_ready !== 1'b1) begin bad++; $display("FAIL basic_mrsp_ready got=%b exp=1", a_mrsp_ready); end
        total++; if (a_crsp_valid !== 1'b0) begin bad++; $display("FAIL basic_no_fallthrough got=%b exp=0", a_crsp_valid); end
        tick();
        mrsp_valid = 1'b0;
        mrsp_data  = '0;
        #1;
        total++; if (a_crsp_valid !== 1'b1) begin bad++; $display("FAIL basic_crsp_valid got=%b exp=1", a_crsp_valid); end
        total++; if (a_crsp_id !== 7'd5) begin bad++; $display("FAIL basic_crsp_id got=%0d exp=5", a_crsp_id); end
        total++; if (a_crsp_data !== pat) begin bad++; $display("FAIL basic_crsp_data got=%h exp=a5a5a5a5", a_crsp_data[31:0]); end
        total++; if (a_crsp_error !== 1'b0) begin bad++; $display("FAIL basic_crsp_error got=%b exp=0", a_crsp_error); end
        total++; if (a_inflight !== 3'd0) begin bad++; $display("FAIL basic_inflight0 got=%0d exp=0", a_inflight); end
        // Payload must hold while the cache stalls.
        tick();
        total++; if (a_crsp_id !== 7'd5 || a_crsp_valid !== 1'b1) begin bad++; $display("FAIL basic_hold got=%0d/%b exp=5/1", a_crsp_id, a_crsp_valid); end
        crsp_ready = 1'b1;
        tick();
        crsp_ready = 1'b0;
        #1;
        total++; if (a_crsp_valid !== 1'b0) begin bad++; $display("FAIL basic_popped got=%b exp=0", a_crsp_valid); end
    endtask

    task automatic test_outstanding_cap();
        do_reset();
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_id = 7'(i);
            tick();
        end
        req_id = 7'd4;
        #1;
        total++; if (b_inflight !== 3'd4) begin bad++; $display("FAIL cap_inflight got=%0d exp=4", b_inflight); end
        total++; if (b_req_ready !== 1'b0) begin bad++; $display("FAIL cap_req_ready got=%b exp=0", b_req_ready); end
        total++; if (b_mreq_valid !== 1'b0) begin bad++; $display("FAIL cap_mreq_valid got=%b exp=0", b_mreq_valid); end
        mrsp_valid = 1'b1;
        mrsp_id    = 7'd0;
        #1;
        total++; if (b_req_ready !== 1'b0) begin bad++; $display("FAIL cap_same_cycle got=%b exp=0", b_req_ready); end
        tick();
        mrsp_valid = 1'b0;
        #1;
        total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL cap_d8_reopen got=%b exp=1", b_req_ready); end
        total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL cap_d4_credit got=%b exp=0", a_req_ready); end
        tick();
        req_valid = 1'b0;
        #1;
        total++; if (b_inflight !== 3'd4) begin bad++; $display("FAIL cap_d8_issued got=%0d exp=4", b_inflight); end
        total++; if (a_inflight !== 3'd3) begin bad++; $display("FAIL cap_d4_held got=%0d exp=3", a_inflight); end
    endtask

    task automatic test_buffer_credit();
        do_reset();
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_id = 7'(i);
            tick();
        end
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mrsp_valid = 1'b1;
            mrsp_id    = 7'(10 + i);
            tick();
        end
        mrsp_valid = 1'b0;
        req_valid  = 1'b1;
        req_id     = 7'd20;
        #1;
        total++; if (a_inflight !== 3'd0) begin bad++; $display("FAIL credit_inflight got=%0d exp=0", a_inflight); end
        total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL credit_full_ready got=%b exp=0", a_req_ready); end
        total++; if (a_mreq_valid !== 1'b0) begin bad++; $display("FAIL credit_full_valid got=%b exp=0", a_mreq_valid); end
        total++; if (a_crsp_id !== 7'd10) begin bad++; $display("FAIL credit_head got=%0d exp=10", a_crsp_id); end
        crsp_ready = 1'b1;
        #1;
        total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL credit_pop_comb got=%b exp=0", a_req_ready); end
        tick();
        crsp_ready = 1'b0;
        #1;
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL credit_reopen got=%b exp=1", a_req_ready); end
        total++; if (a_crsp_id !== 7'd11) begin bad++; $display("FAIL credit_head2 got=%0d exp=11", a_crsp_id); end
        tick();
        #1;
        total++; if (a_inflight !== 3'd1 || a_req_ready !== 1'b0) begin bad++; $display("FAIL credit_one_issue got=%0d/%b exp=1/0", a_inflight, a_req_ready); end
        tick();
        req_valid = 1'b0;
        #1;
        total++; if (a_inflight !== 3'd1) begin bad++; $display("FAIL credit_exactly_one got=%0d exp=1", a_inflight); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_id = 7'(i);
            tick();
        end
        req_valid  = 1'b0;
        mrsp_valid = 1'b1;
        mrsp_id    = 7'd1;
        tick();
        // inflight=2, count=1: issue, response and pop together.
        req_valid  = 1'b1;
        req_id     = 7'd3;
        mrsp_id    = 7'd2;
        crsp_ready = 1'b1;
        #1;
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL sim_ready got=%b exp=1", a_req_ready); end
        total++; if (a_crsp_id !== 7'd1) begin bad++; $display("FAIL sim_pop1 got=%0d exp=1", a_crsp_id); end
        tick();
        req_valid  = 1'b0;
        mrsp_valid = 1'b0;
        crsp_ready = 1'b0;
        #1;
        total++; if (a_inflight !== 3'd2) begin bad++; $display("FAIL sim_inflight got=%0d exp=2", a_inflight); end
        total++; if (a_crsp_valid !== 1'b1 || a_crsp_id !== 7'd2) begin bad++; $display("FAIL sim_pop2 got=%b/%0d exp=1/2", a_crsp_valid, a_crsp_id); end
        mrsp_valid = 1'b1;
        mrsp_id    = 7'd3;
        crsp_ready = 1'b1;
        tick();
        mrsp_valid = 1'b0;
        #1;
        total++; if (a_crsp_valid !== 1'b1 || a_crsp_id !== 7'd3) begin bad++; $display("FAIL sim_pop3 got=%b/%0d exp=1/3", a_crsp_valid, a_crsp_id); end
        tick();
        crsp_ready = 1'b0;
        #1;
        total++; if (a_crsp_valid !== 1'b0) begin bad++; $display("FAIL sim_count1 got=%b exp=0", a_crsp_valid); end
        total++; if (a_inflight !== 3'd1) begin bad++; $display("FAIL sim_inflight_end got=%0d exp=1", a_inflight); end
    endtask

    task automatic test_unexpected();
        do_reset();
        mrsp_valid = 1'b1;
        mrsp_id    = 7'd9;
        tick();
        mrsp_valid = 1'b0;
        #1;
        total++; if (a_err !== 1'b1) begin bad++; $display("FAIL unexp_err got=%b exp=1", a_err); end
        total++; if (a_crsp_valid !== 1'b0) begin bad++; $display("FAIL unexp_dropped got=%b exp=0", a_crsp_valid); end
        total++; if (a_inflight !== 3'd0) begin bad++; $display("FAIL unexp_inflight got=%0d exp=0", a_inflight); end
        tick();
        tick();
        total++; if (a_err !== 1'b1) begin bad++; $display("FAIL unexp_sticky got=%b exp=1", a_err); end
        do_reset();
        #1;
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL unexp_cleared got=%b exp=0", a_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_id = 7'(i);
            tick();
        end
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mrsp_valid = 1'b1;
            mrsp_id    = 7'(i);
            tick();
        end
        mrsp_valid = 1'b0;
        req_valid  = 1'b1;
        req_id     = 7'd4;
        tick();
        req_valid = 1'b0;
        #1;
        total++; if (b_inflight !== 3'd3 || b_crsp_valid !== 1'b1) begin bad++; $display("FAIL mid_setup got=%0d/%b exp=3/1", b_inflight, b_crsp_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (b_inflight !== 3'd0 || b_crsp_valid !== 1'b0 || b_err !== 1'b0) begin bad++; $display("FAIL mid_d8_cleared got=%0d/%b/%b exp=0/0/0", b_inflight, b_crsp_valid, b_err); end
        total++; if (a_inflight !== 3'd0 || a_crsp_valid !== 1'b0) begin bad++; $display("FAIL mid_d4_cleared got=%0d/%b exp=0/0", a_inflight, a_crsp_valid); end
        req_valid = 1'b1;
        req_id    = 7'd7;
        tick();
        req_valid  = 1'b0;
        mrsp_valid = 1'b1;
        mrsp_id    = 7'd7;
        mrsp_error = 1'b1;
        tick();
        mrsp_valid = 1'b0;
        mrsp_error = 1'b0;
        #1;
        total++; if (a_crsp_valid !== 1'b1 || a_crsp_id !== 7'd7 || a_crsp_error !== 1'b1) begin bad++; $display("FAIL mid_after got=%b/%0d/%b exp=1/7/1", a_crsp_valid, a_crsp_id, a_crsp_error); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL mid_no_err got=%b exp=0", a_err); end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_basic();
        test_outstanding_cap();
        test_buffer_credit();
        test_simultaneous();
        test_unexpected();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
